// File: rtl/dfm_pkg.sv
// Shared definitions for the DFM register-file command sequencer:
// command bytes, transfer sizes and the controller state encoding.
package dfm_pkg;

    localparam int WR_BYTES = 8;
    localparam int RD_BYTES = 16;
    localparam int RD_AW    = $clog2(RD_BYTES);

    localparam logic [7:0] CMD_CONF_WR = 8'h2A;
    localparam logic [7:0] CMD_DATA_RD = 8'h3A;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WR_DATA   = 3'd1,
        ST_WR_COMMIT = 3'd2,
        ST_RD_SNAP   = 3'd3,
        ST_RD_SEND   = 3'd4
    } state_t;

endpackage

// File: rtl/regfile_ctl.sv
// Host command sequencer: assembles 8-byte configuration writes and
// streams a 16-byte register snapshot over a valid/ready transmit port.
module regfile_ctl
    import dfm_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              rx_vld_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_abort_i,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output logic [7:0]        tx_data_o,
    output logic              reg_rd_en_o,
    output logic [RD_AW-1:0]  reg_rd_addr_o,
    input  logic [7:0]        reg_rd_data_i,
    output logic              reg_wr_en_o,
    output logic [63:0]       reg_wr_data_o,
    output logic              busy_o
);

    state_t            state_r;
    state_t            state_s;
    logic [2:0]        wr_cnt_r;
    logic [RD_AW-1:0]  rd_addr_r;
    logic [63:0]       wr_data_r;
    logic              wr_en_r;
    logic              rd_en_r;
    logic              tx_valid_r;
    logic              busy_r;
    logic              wr_en_s;
    logic              rd_en_s;
    logic              tx_valid_s;
    logic              busy_s;
    logic              tx_hs_s;

    assign tx_hs_s = tx_valid_r & tx_ready_i;

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; abort overrides every other transition.
    always_comb begin
        state_s = state_r;
        if (rx_abort_i) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (rx_vld_i && (rx_data_i == CMD_CONF_WR)) begin
                        state_s = ST_WR_DATA;
                    end else if (rx_vld_i && (rx_data_i == CMD_DATA_RD)) begin
                        state_s = ST_RD_SNAP;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_WR_DATA: begin
                    if (rx_vld_i && (wr_cnt_r == 3'(WR_BYTES - 1))) begin
                        state_s = ST_WR_COMMIT;
                    end else begin
                        state_s = ST_WR_DATA;
                    end
                end
                ST_WR_COMMIT: state_s = ST_IDLE;
                ST_RD_SNAP:   state_s = ST_RD_SEND;
                ST_RD_SEND: begin
                    if (tx_hs_s && (rd_addr_r == RD_AW'(RD_BYTES - 1))) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_RD_SEND;
                    end
                end
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // Output decode from the upcoming state, so the strobes register cleanly.
    always_comb begin
        wr_en_s    = (state_s == ST_WR_COMMIT);
        rd_en_s    = (state_s == ST_RD_SNAP);
        tx_valid_s = (state_s == ST_RD_SEND);
        busy_s     = (state_s != ST_IDLE);
    end

    // Output registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_en_r    <= 1'b0;
            rd_en_r    <= 1'b0;
            tx_valid_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            wr_en_r    <= wr_en_s;
            rd_en_r    <= rd_en_s;
            tx_valid_r <= tx_valid_s;
            busy_r     <= busy_s;
        end
    end

    // Payload assembly and transmit address; abort discards the byte in flight.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_cnt_r  <= 3'd0;
            rd_addr_r <= '0;
            wr_data_r <= 64'd0;
        end else if (rx_abort_i) begin
            wr_cnt_r  <= 3'd0;
            rd_addr_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (rx_vld_i && (rx_data_i == CMD_CONF_WR)) begin
                        wr_cnt_r <= 3'd0;
                    end
                end
                ST_WR_DATA: begin
                    if (rx_vld_i) begin
                        wr_data_r[{wr_cnt_r, 3'b000} +: 8] <= rx_data_i;
                        wr_cnt_r <= wr_cnt_r + 3'd1;
                    end
                end
                ST_RD_SNAP: rd_addr_r <= '0;
                ST_RD_SEND: begin
                    if (tx_hs_s) begin
                        rd_addr_r <= (rd_addr_r == RD_AW'(RD_BYTES - 1)) ?
                                     '0 : rd_addr_r + RD_AW'(1);
                    end
                end
                default: begin
                    wr_cnt_r  <= wr_cnt_r;
                    rd_addr_r <= rd_addr_r;
                end
            endcase
        end
    end

    assign tx_valid_o    = tx_valid_r;
    assign tx_data_o     = tx_valid_r ? reg_rd_data_i : 8'h00;
    assign reg_rd_en_o   = rd_en_r;
    assign reg_rd_addr_o = rd_addr_r;
    assign reg_wr_en_o   = wr_en_r;
    assign reg_wr_data_o = wr_data_r;
    assign busy_o        = busy_r;

endmodule

// File: tb/tb_regfile_ctl.sv
// Self-checking bench for regfile_ctl with a small register-file stand-in
// and a transaction-level model of committed words and streamed bytes.
module tb_regfile_ctl;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        rx_vld_i;
    logic [7:0]  rx_data_i;
    logic        rx_abort_i;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic [7:0]  tx_data_o;
    logic        reg_rd_en_o;
    logic [3:0]  reg_rd_addr_o;
    logic [7:0]  reg_rd_data_i;
    logic        reg_wr_en_o;
    logic [63:0] reg_wr_data_o;
    logic        busy_o;

    regfile_ctl dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .rx_vld_i      (rx_vld_i),
        .rx_data_i     (rx_data_i),
        .rx_abort_i    (rx_abort_i),
        .tx_valid_o    (tx_valid_o),
        .tx_ready_i    (tx_ready_i),
        .tx_data_o     (tx_data_o),
        .reg_rd_en_o   (reg_rd_en_o),
        .reg_rd_addr_o (reg_rd_addr_o),
        .reg_rd_data_i (reg_rd_data_i),
        .reg_wr_en_o   (reg_wr_en_o),
        .reg_wr_data_o (reg_wr_data_o),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Register-file stand-in: bytes 0..7 are gate-time defaults, 8..15 the last written word.
    logic [7:0]  snap [16];
    logic [63:0] env_cfg = 64'd0;
    always @(posedge clk_i) begin
        if (reg_wr_en_o) env_cfg <= reg_wr_data_o;
        if (reg_rd_en_o) begin
            for (int i = 0; i < 16; i++)
                snap[i] <= (i < 8) ? 8'hA0 + 8'(i) : env_cfg[8*(i-8) +: 8];
        end
    end
    assign reg_rd_data_i = snap[reg_rd_addr_o];

    int n_pass = 0;
    int n_total = 0;
    int exp_commits = 0;
    int seen_commits = 0;
    int acc = 0;
    logic [63:0] model_cfg = 64'd0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [7:0] exp_byte(input int i);
        if (i < 8) return 8'hA0 + 8'(i);
        else if (i < 16) return model_cfg[8*(i-8) +: 8];
        else return 8'hXX;
    endfunction

    // Per-cycle compare against the model: committed words, stream order, stall stability.
    always @(negedge clk_i) begin
        if (!rst_n_i) begin
            acc        <= 0;
            prev_stall <= 1'b0;
        end else begin
            if (reg_wr_en_o) begin
                seen_commits <= seen_commits + 1;
                chk("commit_word", reg_wr_data_o, model_cfg);
            end
            if (tx_valid_o) begin
                chk("tx_byte", {56'd0, tx_data_o}, {56'd0, exp_byte(acc)});
                if (prev_stall) chk("tx_stable", {56'd0, tx_data_o}, {56'd0, prev_data});
            end else begin
                chk("tx_idle_data", {56'd0, tx_data_o}, 64'd0);
            end
            prev_stall <= tx_valid_o && !tx_ready_i;
            prev_data  <= tx_data_o;
            if (reg_rd_en_o) acc <= 0;
            else if (tx_valid_o && tx_ready_i) acc <= acc + 1;
        end
    end

    task automatic align();
        @(posedge clk_i); #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_vld_i  = 1'b1;
        rx_data_i = b;
        @(posedge clk_i); #1;
        rx_vld_i  = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while ((busy_o || tx_valid_o) && n < limit) begin
            @(negedge clk_i);
            n++;
        end
        chk("idle_timeout", {63'd0, (n < limit)}, 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, {63'd0, busy_o}, 64'd0);
        chk({tag, "_tx_valid"}, {63'd0, tx_valid_o}, 64'd0);
        chk({tag, "_tx_data"}, {56'd0, tx_data_o}, 64'd0);
        chk({tag, "_wr_en"}, {63'd0, reg_wr_en_o}, 64'd0);
        chk({tag, "_rd_en"}, {63'd0, reg_rd_en_o}, 64'd0);
        chk({tag, "_addr"}, {60'd0, reg_rd_addr_o}, 64'd0);
        chk({tag, "_wr_data"}, reg_wr_data_o, 64'd0);
    endtask

    // Full-rate read: strobe at +1, 16 consecutive valid cycles from +2, then idle.
    task automatic rd_full(input bit pins);
        tx_ready_i = 1'b1;
        send_byte(8'h3A);
        @(negedge clk_i);
        chk("rd_snap_en", {63'd0, reg_rd_en_o}, 64'd1);
        chk("rd_snap_valid", {63'd0, tx_valid_o}, 64'd0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_i);
            chk("rd_valid", {63'd0, tx_valid_o}, 64'd1);
            chk("rd_addr", {60'd0, reg_rd_addr_o}, 64'(i));
            chk("rd_en_once", {63'd0, reg_rd_en_o}, 64'd0);
            if (pins && i == 0)  chk("pin_byte0", {56'd0, tx_data_o}, 64'hA0);
            if (pins && i == 8)  chk("pin_byte8", {56'd0, tx_data_o}, 64'h01);
            if (pins && i == 15) chk("pin_byte15", {56'd0, tx_data_o}, 64'h08);
        end
        @(negedge clk_i);
        chk("rd_end_valid", {63'd0, tx_valid_o}, 64'd0);
        chk("rd_end_busy", {63'd0, busy_o}, 64'd0);
        chk("rd_end_count", 64'(acc), 64'd16);
        align();
    endtask

    initial begin
        int n;
        rst_n_i = 1'b0; rx_vld_i = 1'b0; rx_data_i = 8'h00;
        rx_abort_i = 1'b0; tx_ready_i = 1'b1;
        #3;
        check_all_zero("reset");
        align();
        rst_n_i = 1'b1;
        align();

        // Configuration write 2A, 01..08.
        model_cfg = 64'h0807060504030201;
        exp_commits++;
        send_byte(8'h2A);
        for (int b = 1; b <= 8; b++) send_byte(8'(b));
        @(negedge clk_i);
        chk("wr_en_pulse", {63'd0, reg_wr_en_o}, 64'd1);
        chk("wr_word", reg_wr_data_o, 64'h0807060504030201);
        @(negedge clk_i);
        chk("wr_en_off", {63'd0, reg_wr_en_o}, 64'd0);
        chk("wr_busy_off", {63'd0, busy_o}, 64'd0);
        chk("wr_word_hold", reg_wr_data_o, 64'h0807060504030201);
        align();

        rd_full(1'b1);

        // Unknown byte in IDLE.
        send_byte(8'h55);
        @(negedge clk_i);
        chk("unk_busy", {63'd0, busy_o}, 64'd0);
        chk("unk_rd_en", {63'd0, reg_rd_en_o}, 64'd0);
        align();

        // Read under pseudo-random back-pressure.
        tx_ready_i = 1'b0;
        send_byte(8'h3A);
        n = 0;
        while (busy_o && n < 400) begin
            tx_ready_i = 1'($urandom_range(0, 1));
            align();
            n++;
        end
        tx_ready_i = 1'b1;
        chk("bp_timeout", {63'd0, (n < 400)}, 64'd1);
        chk("bp_count", 64'(acc), 64'd16);
        align();

        // Command bytes arriving during a read are dropped.
        send_byte(8'h3A);
        send_byte(8'h2A);
        send_byte(8'h3A);
        send_byte(8'h55);
        wait_idle(40);
        chk("ign_count", 64'(acc), 64'd16);
        @(negedge clk_i);
        chk("ign_busy", {63'd0, busy_o}, 64'd0);
        align();

        // Abort mid-write, then a fresh full write.
        send_byte(8'h2A);
        for (int b = 0; b < 4; b++) send_byte(8'hA1 + 8'(b));
        rx_abort_i = 1'b1;
        align();
        rx_abort_i = 1'b0;
        @(negedge clk_i);
        chk("abort_busy", {63'd0, busy_o}, 64'd0);
        chk("abort_no_wr", {63'd0, reg_wr_en_o}, 64'd0);
        align();
        model_cfg = 64'h1817161514131211;
        exp_commits++;
        send_byte(8'h2A);
        for (int b = 0; b < 8; b++) send_byte(8'h11 + 8'(b));
        @(negedge clk_i);
        chk("wr2_en", {63'd0, reg_wr_en_o}, 64'd1);
        chk("wr2_word", reg_wr_data_o, 64'h1817161514131211);
        align();

        // Abort together with a command byte discards the command.
        rx_abort_i = 1'b1;
        send_byte(8'h3A);
        rx_abort_i = 1'b0;
        @(negedge clk_i);
        chk("abort_cmd_busy", {63'd0, busy_o}, 64'd0);
        chk("abort_cmd_rd_en", {63'd0, reg_rd_en_o}, 64'd0);
        align();

        // Abort during the stream drops tx_valid next cycle.
        send_byte(8'h3A);
        align(); align(); align();
        rx_abort_i = 1'b1;
        align();
        rx_abort_i = 1'b0;
        @(negedge clk_i);
        chk("abort_rd_valid", {63'd0, tx_valid_o}, 64'd0);
        chk("abort_rd_addr", {60'd0, reg_rd_addr_o}, 64'd0);
        align();

        rd_full(1'b0);

        // Asynchronous reset during the stream at address 7.
        send_byte(8'h3A);
        n = 0;
        while (!(tx_valid_o && reg_rd_addr_o == 4'd7) && n < 40) begin
            @(negedge clk_i);
            n++;
        end
        chk("rst_reach_addr7", {63'd0, (n < 40)}, 64'd1);
        #2 rst_n_i = 1'b0;
        #1;
        check_all_zero("midrst");
        align();
        rst_n_i = 1'b1;
        align();
        rd_full(1'b0);

        chk("commit_count", 64'(seen_commits), 64'(exp_commits));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regfile_ctl.md
Name: regfile_ctl

Overview:
Command sequencer for the DFM register file. It takes a received host byte stream and decodes two commands. The configuration-write command assembles 8 payload bytes into the 64-bit word and commits it with a single write strobe. The data-read command pulses the snapshot strobe and then streams all 16 register bytes out over a valid/ready transmit port. It sits between the host byte link (SPI/UART byte layer) and the register file.

Parameters:
WR_BYTES, 8, payload bytes per configuration write; fixed by the 64-bit write word.
RD_BYTES, 16, bytes streamed per data read; register address width is clog2(RD_BYTES) = 4.

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  asynchronous active-low reset
rx_vld_i  in  1  one-cycle strobe, rx_data_i holds a received byte
rx_data_i  in  8  received byte
rx_abort_i  in  1  frame abort (chip-select release / framing error)
tx_valid_o  out  1  tx_data_o valid
tx_ready_i  in  1  byte sink accepts tx_data_o
tx_data_o  out  8  outgoing register byte
reg_rd_en_o  out  1  register-file snapshot strobe
reg_rd_addr_o  out  4  register-file read address
reg_rd_data_i  in  8  register-file read data (combinational from address)
reg_wr_en_o  out  1  register-file write strobe
reg_wr_data_o  out  64  assembled configuration word
busy_o  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_n_i is asynchronous and active-low.
- Reset values: all outputs 0, state IDLE, byte counter 0, reg_rd_addr_o 0, reg_wr_data_o 0.
- States: IDLE, WR_DATA, WR_COMMIT, RD_SNAP, RD_SEND.
- IDLE:
  - rx_vld_i with CMD_CONF_WR (8'h2A) -> WR_DATA, counter cleared.
  - rx_vld_i with CMD_DATA_RD (8'h3A) -> RD_SNAP.
  - Any other byte is ignored; stay in IDLE.
- WR_DATA:
  - Byte k (0-based) is stored into reg_wr_data_o[8k+7:8k], so the first payload byte lands in bits 7:0.
  - The counter increments per rx_vld_i.
  - On byte 7 -> WR_COMMIT.
- WR_COMMIT:
  - reg_wr_en_o is high for exactly one cycle, the cycle after the 8th byte strobe.
  - reg_wr_data_o is stable in that cycle and holds its value afterwards.
  - Next state IDLE.
- RD_SNAP:
  - reg_rd_en_o is high for exactly one cycle, the cycle after the command strobe.
  - reg_rd_addr_o = 0. Next state RD_SEND.
- RD_SEND:
  - Entered 2 cycles after the command strobe, once the snapshot bytes are updated.
  - tx_valid_o = 1 and tx_data_o = reg_rd_data_i at address reg_rd_addr_o.
  - On tx_valid_o & tx_ready_i: the address increments next cycle.
  - The handshake at address 15 -> IDLE, with tx_valid_o low the next cycle. The address returns to 0 with no wrap beyond 15.
  - tx_valid_o, once high, stays high until accepted; tx_data_o stays stable while valid and not ready.
- rx_vld_i in WR_COMMIT, RD_SNAP or RD_SEND: the byte is ignored, with no command queuing.
- rx_abort_i, any state: next state is IDLE and the counter and address are cleared.
  - No reg_wr_en_o pulse for a partial payload.
  - tx_valid_o drops the next cycle.
  - Abort takes priority over a simultaneous rx_vld_i, so a command byte in the same cycle is discarded.
  - Abort in the same cycle as a WR_COMMIT or RD_SNAP strobe does not cancel that strobe; its register-file effect is already committed.
- Reset mid-operation: everything returns to the reset values immediately (asynchronously); no strobe is issued.
- Transmit is gated only by tx_ready_i; back-to-back bytes are allowed, 16 bytes in 16 cycles at full ready.

Decomposition:
- Shared package (dfm_pkg): command constants CMD_CONF_WR = 8'h2A and CMD_DATA_RD = 8'h3A, the controller state enum, and WR_BYTES / RD_BYTES.
- No sub-module; byte assembly and the transmit counter stay inline in a single FSM module.

Test Plan:
- Config write: 2A then 01..08 -> one-cycle reg_wr_en_o 1 cycle after byte 08, reg_wr_data_o = 64'h0807060504030201, busy_o low afterwards.
- Data read, tx_ready_i tied high: 3A -> reg_rd_en_o at +1, tx_valid_o from +2 for 16 consecutive cycles, addresses 0..15. Bytes 8..15 match the last write; bytes 0..7 match the default gate-time constants.
- Back-pressure: tx_ready_i toggled pseudo-randomly during a read -> tx_data_o stable while stalled, exactly 16 accepted bytes, no duplicates or skips.
- Abort mid-write: 2A, 4 payload bytes, then rx_abort_i -> no reg_wr_en_o, IDLE. A following full write commits only its own 8 bytes.
- Unknown and ignored bytes: 55 in IDLE -> no strobes, busy_o stays 0. Bytes received during RD_SEND -> the stream is unaffected.
- Reset during RD_SEND at address 7 -> all outputs 0 immediately. After reset release, 3A restarts the stream at address 0.
